// File: rtl/tp_debug_mux_if.sv
// Signal bundle between a test-point mux client and tp_debug_mux.
// The master drives group data and controls; the slave returns test-point and trigger state.
interface tp_debug_mux_if #(
    parameter int unsigned NGRP  = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SELW  = 2,
    parameter int unsigned TBW   = 4,
    parameter int unsigned CNTW  = 16
);
    logic [NGRP*WIDTH-1:0] grp_data;
    logic [SELW-1:0]       sel;
    logic                  sel_ld;
    logic [WIDTH-1:0]      stretch_en;
    logic [TBW-1:0]        trig_bit;
    logic                  arm;
    logic                  cnt_clr;
    logic [WIDTH-1:0]      tp_out;
    logic [SELW-1:0]       sel_act;
    logic                  sel_err;
    logic                  armed;
    logic                  trig_seen;
    logic [WIDTH-1:0]      snap;
    logic [CNTW-1:0]       trig_cnt;

    modport master (
        output grp_data, sel, sel_ld, stretch_en, trig_bit, arm, cnt_clr,
        input  tp_out, sel_act, sel_err, armed, trig_seen, snap, trig_cnt
    );

    modport slave (
        input  grp_data, sel, sel_ld, stretch_en, trig_bit, arm, cnt_clr,
        output tp_out, sel_act, sel_err, armed, trig_seen, snap, trig_cnt
    );
endinterface

// File: rtl/tp_debug_mux.sv
// Debug test-point driver: group select, per-bit pulse stretching and an armed
// single-shot trigger with word snapshot and saturating trigger counter.
module tp_debug_mux #(
    parameter int unsigned NGRP    = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SELW    = 2,
    parameter int unsigned TBW     = 4,
    parameter int unsigned STRETCH = 8,
    parameter int unsigned CNTW    = 16
) (
    input logic           clk,
    input logic           rst_b,
    tp_debug_mux_if.slave bus
);
    localparam int unsigned   CW      = $clog2(STRETCH);
    localparam logic [CW-1:0] CntLoad = CW'(STRETCH - 1);
    localparam logic [SELW:0] NgrpLim = (SELW + 1)'(NGRP);

    logic [NGRP*WIDTH-1:0] in_q;
    logic [SELW-1:0]       sel_act_q, sel_act_d;
    logic                  switch_q, switch_d;
    logic                  sel_err_q, sel_err_d;
    logic [WIDTH-1:0]      prev_q;
    logic [WIDTH-1:0]      mux;
    logic [WIDTH-1:0]      rise;
    logic [WIDTH-1:0]      tp_out_q, tp_out_d;
    logic [CW-1:0]         cnt_q [WIDTH];
    logic [CW-1:0]         cnt_d [WIDTH];
    logic                  armed_q, armed_d;
    logic                  seen_q, seen_d;
    logic [WIDTH-1:0]      snap_q, snap_d;
    logic [CNTW-1:0]       tcnt_q, tcnt_d;
    logic                  trig_src;
    logic                  fire;

    always_comb begin
        mux = '0;
        for (int g = 0; g < int'(NGRP); g++) begin
            if (sel_act_q == SELW'(g)) mux = in_q[g*WIDTH +: WIDTH];
        end
    end

    // The first cycle on a new group must not see the old group's word as an edge.
    assign rise = switch_q ? '0 : (mux & ~prev_q);

    always_comb begin
        sel_act_d = sel_act_q;
        switch_d  = 1'b0;
        sel_err_d = bus.sel_ld & ({1'b0, bus.sel} >= NgrpLim);
        if (bus.sel_ld && ({1'b0, bus.sel} < NgrpLim) && (bus.sel != sel_act_q)) begin
            sel_act_d = bus.sel;
            switch_d  = 1'b1;
        end
    end

    always_comb begin
        tp_out_d = mux;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (!switch_q && bus.stretch_en[i]) begin
                if (rise[i]) begin
                    cnt_d[i] = CntLoad;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
                tp_out_d[i] = mux[i] | (cnt_q[i] != '0);
            end
        end
        if (switch_q) tp_out_d = '0;
    end

    // Indices at or beyond WIDTH match no bit, so the trigger can never fire.
    always_comb begin
        trig_src = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (bus.trig_bit == TBW'(i)) trig_src = rise[i];
        end
    end

    assign fire = armed_q & ~bus.arm & trig_src;

    always_comb begin
        armed_d = armed_q;
        seen_d  = seen_q;
        snap_d  = snap_q;
        tcnt_d  = tcnt_q;
        if (bus.arm) begin
            armed_d = 1'b1;
            seen_d  = 1'b0;
        end else if (fire) begin
            armed_d = 1'b0;
            seen_d  = 1'b1;
            snap_d  = mux;
        end
        if (bus.cnt_clr) begin
            tcnt_d = '0;
        end else if (fire && (tcnt_q != '1)) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_q      <= '0;
            sel_act_q <= '0;
            switch_q  <= 1'b0;
            sel_err_q <= 1'b0;
            prev_q    <= '0;
            tp_out_q  <= '0;
            armed_q   <= 1'b0;
            seen_q    <= 1'b0;
            snap_q    <= '0;
            tcnt_q    <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            in_q      <= bus.grp_data;
            sel_act_q <= sel_act_d;
            switch_q  <= switch_d;
            sel_err_q <= sel_err_d;
            prev_q    <= mux;
            tp_out_q  <= tp_out_d;
            armed_q   <= armed_d;
            seen_q    <= seen_d;
            snap_q    <= snap_d;
            tcnt_q    <= tcnt_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.tp_out    = tp_out_q;
    assign bus.sel_act   = sel_act_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.armed     = armed_q;
    assign bus.trig_seen = seen_q;
    assign bus.snap      = snap_q;
    assign bus.trig_cnt  = tcnt_q;
endmodule

// File: tb/tb_tp_debug_mux.sv
// Directed and randomized bench for tp_debug_mux; the random phase is scored against
// a timestamp-based model of stretching and a rule-level model of select and trigger.
module tb_tp_debug_mux;
    localparam int unsigned NGRP    = 3;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned SELW    = 2;
    localparam int unsigned TBW     = 5;
    localparam int unsigned STRETCH = 8;
    localparam int unsigned CNTW    = 2;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tp_debug_mux_if #(.NGRP(NGRP), .WIDTH(WIDTH), .SELW(SELW), .TBW(TBW), .CNTW(CNTW)) bus ();

    tp_debug_mux #(
        .NGRP(NGRP), .WIDTH(WIDTH), .SELW(SELW), .TBW(TBW), .STRETCH(STRETCH), .CNTW(CNTW)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    // Reference model state (values the DUT registers should hold after the last edge).
    logic [NGRP*WIDTH-1:0] m_in;
    int                    m_sel;
    bit                    m_switch, m_err, m_armed, m_seen;
    logic [WIDTH-1:0]      m_prev, m_tp, m_snap;
    int                    m_cnt;
    int                    m_last [WIDTH];
    bit                    m_lval [WIDTH];
    int                    t;

    task automatic model_reset();
        m_in = '0; m_sel = 0; m_switch = 0; m_err = 0; m_armed = 0; m_seen = 0;
        m_prev = '0; m_tp = '0; m_snap = '0; m_cnt = 0; t = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            m_last[i] = 0;
            m_lval[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [WIDTH-1:0] mux, rise, tp_n;
        bit fire;
        int tb_i;
        mux  = m_in[m_sel*WIDTH +: WIDTH];
        rise = m_switch ? '0 : (mux & ~m_prev);
        // A bit is stretched while fewer than STRETCH cycles have passed since its last edge.
        for (int i = 0; i < int'(WIDTH); i++) begin
            tp_n[i] = mux[i];
            if (bus.stretch_en[i] && m_lval[i] && (t - m_last[i] < int'(STRETCH))) tp_n[i] = 1'b1;
        end
        if (m_switch) tp_n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!bus.stretch_en[i] || m_switch) m_lval[i] = 0;
            else if (rise[i]) begin
                m_lval[i] = 1;
                m_last[i] = t;
            end
        end
        tb_i = int'(bus.trig_bit);
        fire = m_armed && !bus.arm && (tb_i < int'(WIDTH)) && rise[tb_i];
        if (bus.arm) begin
            m_armed = 1; m_seen = 0;
        end else if (fire) begin
            m_armed = 0; m_seen = 1; m_snap = mux;
        end
        if (bus.cnt_clr) m_cnt = 0;
        else if (fire && m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
        m_err = bus.sel_ld && (int'(bus.sel) >= int'(NGRP));
        m_switch = 0;
        if (bus.sel_ld && int'(bus.sel) < int'(NGRP) && int'(bus.sel) != m_sel) begin
            m_sel = int'(bus.sel);
            m_switch = 1;
        end
        m_prev = mux;
        m_in = bus.grp_data;
        m_tp = tp_n;
        t++;
    endtask

    task automatic tick();
        if (!rst_b) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_group(input int g, input logic [WIDTH-1:0] w);
        bus.grp_data[g*WIDTH +: WIDTH] = w;
    endtask

    task automatic clear_inputs();
        bus.grp_data = '0; bus.sel = '0; bus.sel_ld = 0; bus.stretch_en = '0;
        bus.trig_bit = '0; bus.arm = 0; bus.cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst_b = 0;
        for (int g = 0; g < int'(NGRP); g++) set_group(g, WIDTH'($urandom));
        bus.sel = 2'd1; bus.sel_ld = 1; bus.arm = 1; bus.stretch_en = '1; bus.trig_bit = 5'd3;
        repeat (3) tick();
        n_checks++;
        if (bus.tp_out !== '0) begin
            n_fail++; $display("FAIL reset_tp_out: got %h expected 0", bus.tp_out);
        end
        n_checks++;
        if ({bus.sel_act, bus.sel_err, bus.armed, bus.trig_seen} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0",
                               {bus.sel_act, bus.sel_err, bus.armed, bus.trig_seen});
        end
        n_checks++;
        if ({bus.snap, bus.trig_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_trig: got %h expected 0", {bus.snap, bus.trig_cnt});
        end
        clear_inputs();
        rst_b = 1;
        repeat (2) tick();
    endtask

    task automatic test_latency();
        set_group(0, 16'hA5A5);
        tick();
        n_checks++;
        if (bus.tp_out !== 16'h0000) begin
            n_fail++; $display("FAIL latency_t1: got %h expected 0000", bus.tp_out);
        end
        tick();
        n_checks++;
        if (bus.tp_out !== 16'hA5A5) begin
            n_fail++; $display("FAIL latency_t2: got %h expected a5a5", bus.tp_out);
        end
    endtask

    task automatic test_select();
        set_group(2, 16'h3C3C);
        tick();
        bus.sel = 2'd2; bus.sel_ld = 1;
        tick();
        bus.sel_ld = 0;
        n_checks++;
        if (bus.sel_act !== 2'd2 || bus.tp_out !== 16'hA5A5) begin
            n_fail++; $display("FAIL sel_switch: got act=%0d tp=%h expected act=2 tp=a5a5",
                               bus.sel_act, bus.tp_out);
        end
        tick();
        n_checks++;
        if (bus.tp_out !== 16'h0000) begin
            n_fail++; $display("FAIL sel_marker: got %h expected 0000", bus.tp_out);
        end
        tick();
        n_checks++;
        if (bus.tp_out !== 16'h3C3C) begin
            n_fail++; $display("FAIL sel_new_data: got %h expected 3c3c", bus.tp_out);
        end
        bus.sel = 2'd3; bus.sel_ld = 1;
        tick();
        bus.sel_ld = 0;
        n_checks++;
        if (bus.sel_err !== 1'b1 || bus.sel_act !== 2'd2) begin
            n_fail++; $display("FAIL sel_bad: got err=%b act=%0d expected err=1 act=2",
                               bus.sel_err, bus.sel_act);
        end
        tick();
        n_checks++;
        if (bus.sel_err !== 1'b0) begin
            n_fail++; $display("FAIL sel_err_pulse: got %b expected 0", bus.sel_err);
        end
        bus.sel = 2'd2; bus.sel_ld = 1;
        tick();
        bus.sel_ld = 0;
        tick();
        n_checks++;
        if (bus.sel_err !== 1'b0 || bus.tp_out !== 16'h3C3C) begin
            n_fail++; $display("FAIL sel_same: got err=%b tp=%h expected err=0 tp=3c3c",
                               bus.sel_err, bus.tp_out);
        end
        bus.sel = 2'd0; bus.sel_ld = 1;
        tick();
        bus.sel_ld = 0;
        set_group(0, 16'h0000);
        repeat (3) tick();
    endtask

    task automatic run_pulse(input bit en, input int gap, output int highs);
        bus.stretch_en = en ? 16'h0020 : 16'h0000;
        repeat (2) tick();
        highs = 0;
        for (int c = 0; c < 30; c++) begin
            set_group(0, (c == 0 || (gap > 0 && c == gap)) ? 16'h0020 : 16'h0000);
            tick();
            highs += int'(bus.tp_out[5]);
        end
    endtask

    task automatic test_stretch();
        int highs;
        run_pulse(1, 0, highs);
        n_checks++;
        if (highs !== 8) begin
            n_fail++; $display("FAIL stretch_single: got %0d cycles expected 8", highs);
        end
        run_pulse(1, 4, highs);
        n_checks++;
        if (highs !== 12) begin
            n_fail++; $display("FAIL stretch_retrig: got %0d cycles expected 12", highs);
        end
        run_pulse(0, 0, highs);
        n_checks++;
        if (highs !== 1) begin
            n_fail++; $display("FAIL stretch_off: got %0d cycles expected 1", highs);
        end
        bus.stretch_en = '0;
    endtask

    task automatic test_trigger();
        bus.trig_bit = 5'd3;
        set_group(0, 16'h0000);
        repeat (2) tick();
        bus.arm = 1;
        tick();
        bus.arm = 0;
        n_checks++;
        if (bus.armed !== 1'b1 || bus.trig_seen !== 1'b0) begin
            n_fail++; $display("FAIL trig_arm: got armed=%b seen=%b expected 1/0",
                               bus.armed, bus.trig_seen);
        end
        set_group(0, 16'h1238);
        repeat (2) tick();
        n_checks++;
        if ({bus.snap, bus.trig_seen, bus.armed, bus.trig_cnt} !== {16'h1238, 1'b1, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL trig_fire: got snap=%h seen=%b armed=%b cnt=%0d expected 1238/1/0/1",
                               bus.snap, bus.trig_seen, bus.armed, bus.trig_cnt);
        end
        set_group(0, 16'h0000);
        tick();
        set_group(0, 16'hFFFF);
        repeat (2) tick();
        n_checks++;
        if (bus.snap !== 16'h1238 || bus.trig_cnt !== 2'd1) begin
            n_fail++; $display("FAIL trig_oneshot: got snap=%h cnt=%0d expected 1238/1",
                               bus.snap, bus.trig_cnt);
        end
    endtask

    task automatic fire_once(input logic [WIDTH-1:0] w, input bit clr_on_fire);
        bus.arm = 1;
        set_group(0, 16'h0000);
        tick();
        bus.arm = 0;
        tick();
        set_group(0, w);
        tick();
        bus.cnt_clr = clr_on_fire;
        tick();
        bus.cnt_clr = 0;
    endtask

    task automatic test_boundaries();
        set_group(0, 16'h0000);
        repeat (2) tick();
        set_group(0, 16'h0008);
        tick();
        bus.arm = 1;
        tick();
        bus.arm = 0;
        repeat (2) tick();
        n_checks++;
        if (bus.armed !== 1'b1 || bus.trig_seen !== 1'b0 || bus.trig_cnt !== 2'd1) begin
            n_fail++; $display("FAIL arm_same_edge: got armed=%b seen=%b cnt=%0d expected 1/0/1",
                               bus.armed, bus.trig_seen, bus.trig_cnt);
        end
        bus.cnt_clr = 1;
        tick();
        bus.cnt_clr = 0;
        n_checks++;
        if (bus.trig_cnt !== 2'd0) begin
            n_fail++; $display("FAIL cnt_clr: got %0d expected 0", bus.trig_cnt);
        end
        for (int k = 1; k <= 5; k++) fire_once(WIDTH'(16'h0008 | (k << 8)), 0);
        n_checks++;
        if (bus.trig_cnt !== 2'd3 || bus.snap !== 16'h0508) begin
            n_fail++; $display("FAIL cnt_saturate: got cnt=%0d snap=%h expected 3/0508",
                               bus.trig_cnt, bus.snap);
        end
        fire_once(16'h5A08, 1);
        n_checks++;
        if (bus.trig_cnt !== 2'd0 || bus.snap !== 16'h5A08 || bus.trig_seen !== 1'b1) begin
            n_fail++; $display("FAIL clr_vs_fire: got cnt=%0d snap=%h seen=%b expected 0/5a08/1",
                               bus.trig_cnt, bus.snap, bus.trig_seen);
        end
        bus.trig_bit = 5'd20;
        fire_once(16'hFFFF, 0);
        n_checks++;
        if (bus.trig_seen !== 1'b0 || bus.armed !== 1'b1 || bus.snap !== 16'h5A08) begin
            n_fail++; $display("FAIL trig_bit_range: got seen=%b armed=%b snap=%h expected 0/1/5a08",
                               bus.trig_seen, bus.armed, bus.snap);
        end
        bus.trig_bit = 5'd3;
    endtask

    task automatic test_async_reset();
        int highs;
        bus.stretch_en = 16'hFFFF;
        set_group(0, 16'h0000);
        repeat (2) tick();
        set_group(0, 16'h0020);
        tick();
        set_group(0, 16'h0000);
        repeat (3) tick();
        n_checks++;
        if (bus.tp_out !== 16'h0020) begin
            n_fail++; $display("FAIL pre_reset_stretch: got %h expected 0020", bus.tp_out);
        end
        #2 rst_b = 0;
        #1;
        n_checks++;
        if ({bus.tp_out, bus.armed, bus.snap, bus.trig_cnt} !== '0) begin
            n_fail++; $display("FAIL async_reset: got tp=%h armed=%b snap=%h cnt=%0d expected all 0",
                               bus.tp_out, bus.armed, bus.snap, bus.trig_cnt);
        end
        model_reset();
        tick();
        rst_b = 1;
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            highs += int'(bus.tp_out != '0);
        end
        n_checks++;
        if (highs !== 0 || bus.armed !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_resume: got high=%0d armed=%b expected 0/0",
                               highs, bus.armed);
        end
    endtask

    task automatic test_random();
        logic [WIDTH+SELW+3+WIDTH+CNTW-1:0] got, exp;
        for (int n = 0; n < 3000; n++) begin
            for (int g = 0; g < int'(NGRP); g++) begin
                if ($urandom_range(0, 2) == 0) set_group(g, WIDTH'($urandom & $urandom & $urandom));
            end
            bus.sel_ld  = ($urandom_range(0, 15) == 0);
            bus.sel     = SELW'($urandom_range(0, 3));
            bus.arm     = ($urandom_range(0, 7) == 0);
            bus.cnt_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) bus.trig_bit = TBW'($urandom_range(0, 19));
            if ($urandom_range(0, 63) == 0) bus.stretch_en = WIDTH'($urandom);
            tick();
            got = {bus.tp_out, bus.sel_act, bus.sel_err, bus.armed, bus.trig_seen, bus.snap,
                   bus.trig_cnt};
            exp = {m_tp, SELW'(m_sel), m_err, m_armed, m_seen, m_snap, CNTW'(m_cnt)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got tp=%h act=%0d err=%b armed=%b seen=%b snap=%h cnt=%0d expected tp=%h act=%0d err=%b armed=%b seen=%b snap=%h cnt=%0d",
                         n, bus.tp_out, bus.sel_act, bus.sel_err, bus.armed, bus.trig_seen,
                         bus.snap, bus.trig_cnt, m_tp, m_sel, m_err, m_armed, m_seen, m_snap,
                         m_cnt);
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_latency();
        test_select();
        test_stretch();
        test_trigger();
        test_boundaries();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
